// File: rtl/fp_narrow_if.sv
// Stream handshake bundle for fp_narrow: input sample + rounding mode upstream,
// narrowed sample + clamp flag downstream.
interface fp_narrow_if #(
  parameter int IN_W  = 13,
  parameter int OUT_W = 7
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [1:0]       rnd_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_sat;

  modport master (
    output in_valid, in_data, rnd_mode, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, rnd_mode, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/fp_narrow.sv
// Fixed-point narrowing: S1 rounds away D fraction bits, S2 saturates to the
// output format. Two-entry elastic pipeline with a saturation event counter.
module fp_narrow #(
  parameter int IN_INT   = 8,
  parameter int IN_FRAC  = 5,
  parameter int OUT_INT  = 4,
  parameter int OUT_FRAC = 3
) (
  input  logic       clk,
  input  logic       rst,
  fp_narrow_if.slave bus,
  input  logic       clr_count,
  output logic [7:0] sat_count
);
  localparam int IN_W  = IN_INT + IN_FRAC;
  localparam int OUT_W = OUT_INT + OUT_FRAC;
  localparam int D     = IN_FRAC - OUT_FRAC;

  localparam logic signed [IN_W:0] MAXV = (IN_W+1)'(2**(OUT_W-1) - 1);
  localparam logic signed [IN_W:0] MINV = (IN_W+1)'(-(2**(OUT_W-1)));

  logic                   s1_v, s2_v, s2_ready;
  logic signed [IN_W:0]   ext, rnd, s1_r;
  logic                   hi, lo;
  logic [OUT_W-1:0]       sat_data;

  assign s2_ready      = !s2_v || bus.out_ready;
  assign bus.in_ready  = rst && (!s1_v || s2_ready);
  assign bus.out_valid = s2_v;

  // One guard bit above the input so a rounding carry out of the max value never wraps.
  assign ext = {bus.in_data[IN_W-1], bus.in_data};

  generate
    if (D == 0) begin : g_bypass
      assign rnd = ext;
    end else begin : g_rnd
      localparam logic signed [IN_W:0] HALF = (IN_W+1)'(2**(D-1));
      logic signed [IN_W:0] bias, sum;
      always_comb begin
        bias = '0;
        case (bus.rnd_mode)
          2'b01:   bias = HALF;
          2'b10:   bias = HALF - (IN_W+1)'(1) + (IN_W+1)'(bus.in_data[D]);
          default: bias = '0;
        endcase
      end
      assign sum = ext + bias;
      assign rnd = sum >>> D;
    end
  endgenerate

  assign hi       = s1_r > MAXV;
  assign lo       = s1_r < MINV;
  assign sat_data = hi ? MAXV[OUT_W-1:0] : lo ? MINV[OUT_W-1:0] : s1_r[OUT_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_v         <= 1'b0;
      s2_v         <= 1'b0;
      s1_r         <= '0;
      bus.out_data <= '0;
      bus.out_sat  <= 1'b0;
    end else begin
      if (!s1_v || s2_ready) begin
        s1_v <= bus.in_valid;
        if (bus.in_valid) s1_r <= rnd;
      end
      if (s2_ready) begin
        s2_v <= s1_v;
        if (s1_v) begin
          bus.out_data <= sat_data;
          bus.out_sat  <= hi || lo;
        end
      end
    end
  end

  // Counts clamped samples actually handed downstream; sticks at 255.
  always_ff @(posedge clk) begin
    if (!rst || clr_count)
      sat_count <= '0;
    else if (s2_v && bus.out_ready && bus.out_sat && sat_count != 8'hFF)
      sat_count <= sat_count + 8'd1;
  end
endmodule

// File: tb/tb_fp_narrow.sv
// Self-checking bench for fp_narrow: directed rounding/saturation cases, backpressure,
// counter, reset, plus randomized traffic against an arithmetic reference model.
module tb_fp_narrow;
  localparam int IN_INT = 8, IN_FRAC = 5, OUT_INT = 4, OUT_FRAC = 3;
  localparam int IN_W = IN_INT + IN_FRAC, OUT_W = OUT_INT + OUT_FRAC;
  localparam int D = IN_FRAC - OUT_FRAC;
  localparam int P = 2**D;
  localparam int MAXV = 2**(OUT_W-1) - 1, MINV = -(2**(OUT_W-1));

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr_count = 1'b0;
  logic [7:0] sat_count;

  fp_narrow_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus();

  fp_narrow #(.IN_INT(IN_INT), .IN_FRAC(IN_FRAC), .OUT_INT(OUT_INT), .OUT_FRAC(OUT_FRAC)) dut (
    .clk(clk), .rst(rst), .bus(bus), .clr_count(clr_count), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  int ncmp = 0, nerr = 0, acc_cnt = 0;
  int qd[$];
  bit qs[$];

  task automatic chk(input string tag, input int got, input int exp);
    ncmp++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference: real value v/P rounded per mode by quotient/remainder, then clamped.
  function automatic void model(input int v, input int m, output int d, output bit s);
    int q, r;
    if (D == 0) q = v;
    else begin
      r = ((v % P) + P) % P;
      q = (v - r) / P;
      if (m == 1 && r >= P/2) q++;
      else if (m == 2 && (r > P/2 || (r == P/2 && (q % 2) != 0))) q++;
    end
    if (q > MAXV)      begin d = MAXV; s = 1'b1; end
    else if (q < MINV) begin d = MINV; s = 1'b1; end
    else               begin d = q;    s = 1'b0; end
  endfunction

  always @(negedge clk) begin : mon
    int ed, md, iv;
    bit es, ms;
    if (rst) begin
      if (bus.out_valid && bus.out_ready) begin
        if (qd.size() == 0) chk("spurious_out", 1, 0);
        else begin
          ed = qd.pop_front();
          es = qs.pop_front();
          chk("sb_data", $signed(bus.out_data), ed);
          chk("sb_sat", int'(bus.out_sat), int'(es));
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        iv = $signed(bus.in_data);
        model(iv, int'(bus.rnd_mode), md, ms);
        qd.push_back(md);
        qs.push_back(ms);
        acc_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while ((qd.size() != 0 || bus.out_valid) && n < 60) begin
      @(negedge clk); n++;
    end
    chk("drain_left", qd.size(), 0);
  endtask

  task automatic one(input string tag, input int v, input int m, input int exp_d, input int exp_s);
    int n = 0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = IN_W'(v);
    bus.rnd_mode  = 2'(m);
    step();
    bus.in_valid  = 1'b0;
    do begin @(negedge clk); n++; end while (!bus.out_valid && n < 8);
    chk({tag, "_lat"}, n, 2);
    chk({tag, "_data"}, $signed(bus.out_data), exp_d);
    chk({tag, "_sat"}, int'(bus.out_sat), exp_s);
    step();
  endtask

  function automatic int sat_val();
    int v = int'($urandom_range(1024, 4095));
    return ($urandom % 2) ? -v : v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.rnd_mode = 2'b00; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_sat",   int'(bus.out_sat), 0);
    chk("rst_out_data",  int'(bus.out_data), 0);
    chk("rst_sat_count", int'(sat_count), 0);
    chk("rst_in_ready",  int'(bus.in_ready), 0);
    step(); rst = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", int'(bus.in_ready), 1);
    step();

    // Rounding, negative values and saturation at default parameters
    one("r10_m0", 10, 0, 2, 0);
    one("r10_m1", 10, 1, 3, 0);
    one("r10_m2", 10, 2, 2, 0);
    one("r14_m2", 14, 2, 4, 0);
    one("n6_m0", -6, 0, -2, 0);
    one("n6_m1", -6, 1, -1, 0);
    one("n6_m2", -6, 2, -2, 0);
    one("n6_m3", -6, 3, -2, 0);
    one("sat_hi", 4095, 1, 63, 1);
    one("sat_lo", -4096, 0, -64, 1);
    drain();
    chk("sat_count_2", int'(sat_count), 2);

    // Backpressure: two slots fill, then input stalls
    bus.out_ready = 1'b0;
    a0 = acc_cnt;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.in_data = IN_W'($urandom); bus.rnd_mode = 2'($urandom);
      step();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_accepted", acc_cnt - a0, 2);
    chk("bp_in_ready", int'(bus.in_ready), 0);
    chk("bp_hold_valid", int'(bus.out_valid), 1);
    step();
    drain();

    // Randomized traffic with random stalls on both sides
    for (int i = 0; i < 600; i++) begin
      bus.in_valid  = ($urandom % 4) != 0;
      bus.in_data   = ($urandom % 4 == 0) ? IN_W'(sat_val()) : IN_W'($urandom);
      bus.rnd_mode  = 2'($urandom);
      bus.out_ready = ($urandom % 3) != 0;
      step();
    end
    drain();

    // Counter saturates at 255, clear wins over a simultaneous increment
    bus.out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus.in_valid = 1'b1; bus.in_data = IN_W'(sat_val()); bus.rnd_mode = 2'($urandom);
      step();
    end
    drain();
    chk("sat_count_255", int'(sat_count), 255);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = IN_W'(sat_val()); bus.rnd_mode = 2'b00;
    step();
    bus.in_valid = 1'b0;
    step();
    chk("clr_pre_valid", int'(bus.out_valid), 1);
    clr_count = 1'b1; bus.out_ready = 1'b1;
    step();
    clr_count = 1'b0;
    @(negedge clk);
    chk("clr_sat_count", int'(sat_count), 0);
    chk("clr_out_valid", int'(bus.out_valid), 0);
    step();
    drain();

    // Reset with two samples in flight
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1; bus.in_data = IN_W'($urandom); bus.rnd_mode = 2'($urandom);
      step();
    end
    bus.in_valid = 1'b0;
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("mid_rst_out_valid", int'(bus.out_valid), 0);
    chk("mid_rst_in_ready", int'(bus.in_ready), 0);
    qd.delete(); qs.delete();
    step();
    rst = 1'b1; bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst_stale", int'(bus.out_valid), 0);
    end
    step();
    one("after_rst", 10, 1, 3, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
